// File: rtl/life_gen_sequencer.sv
// Purpose: steps the Game of Life array through one generation, row by row (load, compute, store).
// Latency: first load one cycle after a start request; 3*ROWS+1 cycles per generation with no stalls.
// Backpressure: mem_ready low holds LOAD or STORE in place; COMPUTE always takes a single cycle.
module life_gen_sequencer #(
  parameter int ROWS  = 4,
  parameter int ROW_W = 2,
  parameter int GEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_enb,
  input  logic             step,
  input  logic             mem_ready,
  input  logic             row_changed,
  output logic [ROW_W-1:0] row_addr,
  output logic             load_row,
  output logic             compute,
  output logic             store_row,
  output logic             busy,
  output logic             gen_done,
  output logic [GEN_W-1:0] gen_count,
  output logic             stable
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_COMPUTE = 3'd2;
  localparam logic [2:0] S_STORE   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  logic [2:0]       state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             acc_q, acc_d;      // any row of this generation changed
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             stable_q, stable_d;

  // Next-state logic: sequencing, row walk, change accumulation and generation bookkeeping.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    acc_d    = acc_q;
    gen_d    = gen_q;
    stable_d = stable_q;
    case (state_q)
      S_IDLE: begin
        // A step always starts a generation; free-run pauses once the pattern is stable.
        if (step || (run_enb && !stable_q)) begin
          state_d = S_LOAD;
          row_d   = '0;
          acc_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (mem_ready) begin
          state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        acc_d   = acc_q | row_changed;
        state_d = S_STORE;
      end
      S_STORE: begin
        if (mem_ready) begin
          if (row_q == LAST_ROW) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + ROW_W'(1);
            state_d = S_LOAD;
          end
        end
      end
      S_DONE: begin
        gen_d    = gen_q + GEN_W'(1);
        stable_d = ~acc_q;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any generation in flight without touching it further.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      acc_q    <= 1'b0;
      gen_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      acc_q    <= acc_d;
      gen_q    <= gen_d;
      stable_q <= stable_d;
    end
  end

  // Moore outputs, decoded from the registered state only.
  assign row_addr  = row_q;
  assign load_row  = (state_q == S_LOAD);
  assign compute   = (state_q == S_COMPUTE);
  assign store_row = (state_q == S_STORE);
  assign gen_done  = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign gen_count = gen_q;
  assign stable    = stable_q;

endmodule

// File: doc/life_gen_sequencer.md
# life_gen_sequencer

Generation sequencer for the Game of Life cell array. It walks the cell memory row by row. For each row it loads the row into the array, lets the array compute the next state, and writes the row back. It keeps a generation counter and detects when the pattern has become stable. It sits between the top-level run/step controls, the cell memory port and the array.

## Interface
Parameters:
- ROWS, 4, number of rows per generation (≥2)
- ROW_W, 2, width of row_addr (2^ROW_W ≥ ROWS)
- GEN_W, 16, width of gen_count

Ports:
- clk  input  1  system clock; all state changes on posedge
- reset  input  1  asynchronous, active-high; one clock, reset asynchronous and active-high
- run_enb  input  1  free-run request; level, sampled in IDLE
- step  input  1  single-generation request; sampled in IDLE, ignored otherwise
- mem_ready  input  1  cell memory accepts the current load/store this cycle
- row_changed  input  1  array reports that the computed row differs from the loaded row; valid while compute=1
- row_addr  output  ROW_W  row currently being processed
- load_row  output  1  read row_addr from memory into the array
- compute  output  1  array evaluates the next state of the loaded row
- store_row  output  1  write the array result back to row_addr
- busy  output  1  a generation is in progress (state ≠ IDLE)
- gen_done  output  1  one-cycle pulse at the end of each generation
- gen_count  output  GEN_W  number of completed generations, modulo 2^GEN_W
- stable  output  1  the last completed generation changed no row

## Operation
States: IDLE, LOAD, COMPUTE, STORE, DONE. All outputs are Moore-decoded from registered state.
- IDLE:
  - Go to LOAD if step=1, or if run_enb=1 and stable=0. Step has priority and always starts a generation.
  - On entering LOAD: row_addr←0 and the change accumulator is cleared.
- LOAD: load_row=1. Hold while mem_ready=0. Go to COMPUTE the cycle after mem_ready=1.
- COMPUTE: compute=1 for exactly one cycle. Accumulator ← accumulator | row_changed. Always go to STORE.
- STORE: store_row=1. Hold while mem_ready=0. When mem_ready=1:
  - If row_addr==ROWS-1, go to DONE.
  - Otherwise row_addr←row_addr+1 and go to LOAD.
- DONE: gen_done=1 for one cycle.
  - gen_count←gen_count+1, wrapping from all-ones to 0.
  - stable←~accumulator.
  - Go to IDLE.
- Clearing stable:
  - stable is cleared by reset.
  - It is overwritten at every DONE.
  - A step press restarts sequencing even when stable=1.
- Per state, exactly one of load_row, compute, store_row and gen_done is high; in IDLE none are high.
- row_addr holds its value in IDLE and DONE (last row, ROWS-1, after a generation).

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE and the accumulator is cleared.
  - Outputs: row_addr=0, gen_count=0, stable=0, busy=0. All strobes are 0.
- Start latency: run_enb or step high at posedge N in IDLE gives load_row=1 and busy=1 from cycle N+1.
- With mem_ready tied high:
  - Each row takes 3 cycles (LOAD, COMPUTE, STORE).
  - A generation takes 3·ROWS+1 cycles, from the first LOAD through DONE.
  - Free-run period is 3·ROWS+2 cycles, because one IDLE cycle separates generations (14 cycles for ROWS=4).
- mem_ready low stretches LOAD or STORE by one cycle per low cycle. COMPUTE is never stretched.
- Timing of gen_count and stable:
  - Both update at the posedge that leaves DONE.
  - They are visible in the IDLE cycle that follows.
- step or run_enb changing while busy has no effect on the current generation.
- Dropping run_enb mid-generation lets the generation finish, then the block stays in IDLE.
- Reset asserted mid-generation aborts immediately. No further strobes are issued and no partial gen_count update happens.

## Test plan
- Reset, then run_enb=1 with mem_ready=1 and row_changed=1 (ROWS=4):
  - load_row is asserted for row_addr 0,1,2,3.
  - gen_done pulses every 14 cycles.
  - gen_count reads 1, 2, 3 after each pulse.
  - stable=0 throughout.
- Free-run with row_changed=0 for every row:
  - After the first DONE, stable=1 and the block stays in IDLE with busy=0.
  - A step pulse then runs exactly one more generation (gen_count+1) and returns to IDLE.
- Memory stall: mem_ready low for 3 cycles during LOAD of row 2 and 2 cycles during STORE of row 1.
  - load_row is held 4 cycles and store_row 3 cycles respectively.
  - compute is exactly 1 cycle per row.
  - The generation takes 13+5=18 cycles.
- Single row change: row_changed=1 only in the COMPUTE cycle of row 3 → stable=0 after DONE.
- Reset asserted during STORE of row 1:
  - All outputs are 0 in the same cycle (asynchronous).
  - After release with run_enb=1, sequencing restarts at row 0 and gen_count counts from 0.
- Wrap-around with GEN_W=2: after 5 generations gen_count=1. step held high continuously behaves like free-run with the same 14-cycle period.
